// File: rtl/stride_sequence_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : stride_sequence_generator                                   |
// | Description : Bounded up/down stride counter with wrap pulse and          |
// |               oneshot stop. Optional macro SEQGEN_GRAY_OUT_EN adds a      |
// |               combinational Gray-coded copy of Q on port q_gray.          |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module stride_sequence_generator #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             load,
    input  logic             dir,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] start,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] Q,
    output logic             wrap,
`ifdef SEQGEN_GRAY_OUT_EN
    output logic             done,
    output logic [WIDTH-1:0] q_gray
`else
    output logic             done
`endif
);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_done;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_bounds_inverted;
    logic             w_wrap_up;
    logic             w_wrap_dn;
    logic             w_adv;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap;

    // Sum is one bit wider so all-ones plus step never aliases below limit.
    assign w_sum             = {1'b0, r_q} + {1'b0, step};
    assign w_diff            = r_q - step;
    assign w_bounds_inverted = (start > limit);
    assign w_wrap_up         = w_bounds_inverted || (w_sum > {1'b0, limit});
    assign w_wrap_dn         = w_bounds_inverted || (r_q < step) || (w_diff < start);
    assign w_adv             = en && !load && !r_done;

    // Candidate next value and wrap flag for an advance; zero stride is a pure hold.
    always_comb begin
        w_q_next = r_q;
        w_wrap   = 1'b0;
        if (step != '0) begin
            if (!dir) begin
                if (w_wrap_up) begin
                    w_q_next = start;
                    w_wrap   = 1'b1;
                end else begin
                    w_q_next = w_sum[WIDTH-1:0];
                end
            end else begin
                if (w_wrap_dn) begin
                    w_q_next = limit;
                    w_wrap   = 1'b1;
                end else begin
                    w_q_next = w_diff;
                end
            end
        end
    end

    // Sequence state: load beats advance; done freezes Q until load or clear.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_q    <= RESET_VAL;
            r_wrap <= 1'b0;
            r_done <= 1'b0;
        end else if (load) begin
            r_q    <= start;
            r_wrap <= 1'b0;
            r_done <= 1'b0;
        end else if (w_adv) begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap;
            if (w_wrap && oneshot) begin
                r_done <= 1'b1;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign Q    = r_q;
    assign wrap = r_wrap;
    assign done = r_done;

`ifdef SEQGEN_GRAY_OUT_EN
    // Follows Q directly, so it shows Gray(RESET_VAL) while clear is held.
    assign q_gray = r_q ^ (r_q >> 1);
`endif

endmodule
`default_nettype wire

// File: tb/tb_stride_sequence_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_stride_sequence_generator                                |
// | Description : Self-checking bench: two instances (WIDTH 8 and 3) checked  |
// |               every cycle against a behavioural model, plus literal       |
// |               sequence expectations.                                      |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_stride_sequence_generator;

    localparam logic [7:0] c_RST_A = 8'd7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // lane A: WIDTH 8
    logic       clear_a = 1'b0, en_a = 1'b0, load_a = 1'b0, dir_a = 1'b0, os_a = 1'b0;
    logic [7:0] start_a = '0, limit_a = '0, step_a = '0;
    logic [7:0] q_a;
    logic       wrap_a, done_a;
    // lane B: WIDTH 3
    logic       clear_b = 1'b0, en_b = 1'b0, load_b = 1'b0, dir_b = 1'b0, os_b = 1'b0;
    logic [2:0] start_b = '0, limit_b = '0, step_b = '0;
    logic [2:0] q_b;
    logic       wrap_b, done_b;
`ifdef SEQGEN_GRAY_OUT_EN
    logic [7:0] g_a;
    logic [2:0] g_b;
`endif

    stride_sequence_generator #(.WIDTH(8), .RESET_VAL(c_RST_A)) u_a (
        .clk(clk), .clear(clear_a), .en(en_a), .load(load_a), .dir(dir_a),
        .oneshot(os_a), .start(start_a), .limit(limit_a), .step(step_a),
        .Q(q_a), .wrap(wrap_a),
`ifdef SEQGEN_GRAY_OUT_EN
        .done(done_a), .q_gray(g_a)
`else
        .done(done_a)
`endif
    );

    stride_sequence_generator #(.WIDTH(3), .RESET_VAL(3'd0)) u_b (
        .clk(clk), .clear(clear_b), .en(en_b), .load(load_b), .dir(dir_b),
        .oneshot(os_b), .start(start_b), .limit(limit_b), .step(step_b),
        .Q(q_b), .wrap(wrap_b),
`ifdef SEQGEN_GRAY_OUT_EN
        .done(done_b), .q_gray(g_b)
`else
        .done(done_b)
`endif
    );

    // ---------------- behavioural model ----------------
    longint mq_a = 7, mq_b = 0;
    bit     mw_a = 0, md_a = 0, mw_b = 0, md_b = 0;

    task automatic model_step(input bit ld, input bit e, input bit d, input bit os,
                              input longint st, input longint lim, input longint stp,
                              inout longint q, inout bit wr, inout bit dn);
        if (ld) begin
            q = st; wr = 0; dn = 0;
        end else if (e && !dn) begin
            wr = 0;
            if (stp != 0) begin
                if (!d) begin
                    if (st > lim || q + stp > lim) begin q = st; wr = 1; end
                    else q = q + stp;
                end else begin
                    if (st > lim || q < stp || q - stp < st) begin q = lim; wr = 1; end
                    else q = q - stp;
                end
            end
            if (wr && os) dn = 1;
        end else begin
            wr = 0;
        end
    endtask

    always @(posedge clk or posedge clear_a) begin
        if (clear_a) begin mq_a = c_RST_A; mw_a = 0; md_a = 0; end
        else model_step(load_a, en_a, dir_a, os_a, start_a, limit_a, step_a, mq_a, mw_a, md_a);
    end

    always @(posedge clk or posedge clear_b) begin
        if (clear_b) begin mq_b = 0; mw_b = 0; md_b = 0; end
        else model_step(load_b, en_b, dir_b, os_b, start_b, limit_b, step_b, mq_b, mw_b, md_b);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge, DUT against model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_q_a", 64'(q_a), 64'(mq_a));
            check("model_wrap_a", 64'(wrap_a), 64'(mw_a));
            check("model_done_a", 64'(done_a), 64'(md_a));
            check("model_q_b", 64'(q_b), 64'(mq_b));
            check("model_wrap_b", 64'(wrap_b), 64'(mw_b));
            check("model_done_b", 64'(done_b), 64'(md_b));
`ifdef SEQGEN_GRAY_OUT_EN
            check("model_gray_a", 64'(g_a), 64'(mq_a ^ (mq_a >> 1)));
            check("model_gray_b", 64'(g_b), 64'(mq_b ^ (mq_b >> 1)));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    int seq_q[5] = '{1, 3, 5, 7, 1};
    int seq_g[5] = '{1, 2, 7, 4, 1};

    initial begin
        // reset
        #1 clear_a = 1'b1; clear_b = 1'b1;
        @(negedge clk);
        check("reset_q_a", 64'(q_a), 64'(c_RST_A));
        check("reset_wrap_a", 64'(wrap_a), 64'd0);
        check("reset_done_a", 64'(done_a), 64'd0);
        check("reset_q_b", 64'(q_b), 64'd0);
        clear_a = 1'b0; clear_b = 1'b0;
        chk_en = 1'b1;

        // WIDTH 3 free-running sequence 1,3,5,7,1
        start_b = 3'd1; step_b = 3'd2; limit_b = 3'd7; dir_b = 0; os_b = 0;
        load_b = 1; tick(); load_b = 0; en_b = 1;
        for (int i = 0; i < 5; i++) begin
            check("seq031_q", 64'(q_b), 64'(seq_q[i]));
            check("seq031_wrap", 64'(wrap_b), 64'(i == 4));
`ifdef SEQGEN_GRAY_OUT_EN
            check("seq036_gray", 64'(g_b), 64'(seq_g[i]));
`endif
            if (i < 4) tick();
        end

        // oneshot: stops at 1 with done, holds, oneshot drop keeps done, load resumes
        en_b = 0; os_b = 1; load_b = 1; tick(); load_b = 0; en_b = 1;
        for (int i = 0; i < 4; i++) tick();
        check("os_q", 64'(q_b), 64'd1);
        check("os_done", 64'(done_b), 64'd1);
        check("os_wrap", 64'(wrap_b), 64'd1);
        os_b = 0; tick(); tick();
        check("os_hold_q", 64'(q_b), 64'd1);
        check("os_hold_wrap", 64'(wrap_b), 64'd0);
        check("os_sticky_done", 64'(done_b), 64'd1);
        load_b = 1; tick(); load_b = 0;
        check("os_load_done", 64'(done_b), 64'd0);
        tick();
        check("os_resume_q", 64'(q_b), 64'd3);
        en_b = 0;

        // WIDTH 8 down: 40 -> 25,10,40
        dir_a = 1; step_a = 8'd15; limit_a = 8'd40; start_a = 8'd40;
        load_a = 1; tick(); load_a = 0; start_a = 8'd10; en_a = 1;
        check("dn_load", 64'(q_a), 64'd40);
        tick(); check("dn_q1", 64'(q_a), 64'd25);
        tick(); check("dn_q2", 64'(q_a), 64'd10);
        tick(); check("dn_q3", 64'(q_a), 64'd40); check("dn_wrap3", 64'(wrap_a), 64'd1);
        en_a = 0; start_a = 8'd12; load_a = 1; tick(); load_a = 0; start_a = 8'd10; en_a = 1;
        tick(); check("dn_underflow_q", 64'(q_a), 64'd40); check("dn_underflow_wrap", 64'(wrap_a), 64'd1);

        // all-ones up with step 1 wraps to start
        en_a = 0; dir_a = 0; step_a = 8'd1; limit_a = 8'hFF; start_a = 8'hFF;
        load_a = 1; tick(); load_a = 0; start_a = 8'd0; en_a = 1;
        tick(); check("top_q", 64'(q_a), 64'd0); check("top_wrap", 64'(wrap_a), 64'd1);

        // async clear mid-cycle at Q=5 with en high
        en_a = 0; start_a = 8'd5; limit_a = 8'd200; step_a = 8'd3;
        load_a = 1; tick(); load_a = 0; en_a = 1;
        #2 clear_a = 1'b1;
        #1;
        check("aclr_q", 64'(q_a), 64'(c_RST_A));
        check("aclr_wrap", 64'(wrap_a), 64'd0);
        check("aclr_done", 64'(done_a), 64'd0);
        @(negedge clk); clear_a = 1'b0;
        start_a = 8'd20; load_a = 1; en_a = 1; tick(); load_a = 0;
        check("load_en_q", 64'(q_a), 64'd20);

        // randomized phase, both lanes, with occasional mid-cycle clear pulses
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 29) == 0) begin
                #2 clear_a = 1'b1; clear_b = ($urandom_range(0, 1) == 1);
                #2 clear_a = 1'b0; clear_b = 1'b0;
            end
            en_a = ($urandom_range(0, 3) != 0); load_a = ($urandom_range(0, 11) == 0);
            dir_a = $urandom_range(0, 1); os_a = ($urandom_range(0, 5) == 0);
            step_a = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
            start_a = 8'($urandom_range(0, 90)); limit_a = 8'($urandom_range(60, 255));
            if ($urandom_range(0, 19) == 0) begin start_a = 8'd250; limit_a = 8'd3; end
            en_b = ($urandom_range(0, 3) != 0); load_b = ($urandom_range(0, 9) == 0);
            dir_b = $urandom_range(0, 1); os_b = ($urandom_range(0, 5) == 0);
            step_b = 3'($urandom_range(0, 7)); start_b = 3'($urandom_range(0, 7));
            limit_b = 3'($urandom_range(0, 7));
            tick();
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stride_sequence_generator.md
STRIDE_SEQUENCE_GENERATOR -- requirements
Module: stride_sequence_generator

Interface
REQ-001 Parameter WIDTH, default 8: width of the sequence value and of all value ports; legal range 2..32.
REQ-002 Parameter RESET_VAL, default 0: value Q takes on reset; must be representable in WIDTH bits.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 clear  input  1: reset, asynchronous and active-high.
REQ-005 en  input  1: advance enable; when low, Q holds.
REQ-006 load  input  1: synchronous load of start into Q.
REQ-007 dir  input  1: 0 = count up, 1 = count down.
REQ-008 oneshot  input  1: 1 = stop after the first wrap; 0 = free-running.
REQ-009 start  input  WIDTH: lower bound and wrap target for up counting.
REQ-010 limit  input  WIDTH: upper bound and wrap target for down counting.
REQ-011 step  input  WIDTH: unsigned stride added or subtracted per advance.
REQ-012 Q  output  WIDTH: registered sequence value.
REQ-013 wrap  output  1: registered one-cycle pulse, high in the cycle Q holds a wrapped value.
REQ-014 done  output  1: registered sticky flag, set on a wrap while oneshot=1.

Function
REQ-015 Priority per rising edge SHALL be: load, then en; en is ignored while load=1.
REQ-016 On load: Q <= start, wrap <= 0, done <= 0.
REQ-017 Advance SHALL occur only when en=1, load=0 and done=0; otherwise Q holds and wrap <= 0.
REQ-018 Up advance: compute Q+step in WIDTH+1 bits; if the sum > limit, then Q <= start and wrap <= 1; else Q <= sum[WIDTH-1:0] and wrap <= 0.
REQ-019 Down advance: if Q < step or Q-step < start, then Q <= limit and wrap <= 1; else Q <= Q-step and wrap <= 0.
REQ-020 Comparisons SHALL be unsigned and SHALL NOT overflow; up counting at WIDTH'all-ones with step 1 and limit all-ones wraps to start.
REQ-021 step=0: an advance leaves Q unchanged and SHALL NOT raise wrap.
REQ-022 start>limit: every advance in either direction wraps. Up advances force Q <= start; down advances force Q <= limit. Each such advance raises wrap.
REQ-023 A wrap with oneshot=1 SHALL set done in the same edge; Q then holds the wrapped value until load or clear.
REQ-024 oneshot is sampled at the wrapping edge only; deasserting it while done=1 SHALL NOT clear done.
REQ-025 Changing dir, step, start or limit SHALL take effect on the next advance with no extra latency. The current Q is not re-evaluated against the new bounds until that advance.
REQ-026 Latency: one clock from the advance-qualifying edge to the new Q. wrap and done are coincident with the new Q.

Reset
REQ-027 clear=1 SHALL immediately force Q=RESET_VAL, wrap=0 and done=0, independent of clk, including mid-sequence and during load.
REQ-028 After clear deasserts, the first rising edge with en=1 or load=1 SHALL act normally; there are no dead cycles.

Configuration
REQ-029 Macro SEQGEN_GRAY_OUT_EN: when defined, an extra output q_gray [WIDTH] SHALL equal Q ^ (Q >> 1), derived combinationally from registered Q with zero added latency. It is forced to the Gray code of RESET_VAL during clear.
REQ-030 When SEQGEN_GRAY_OUT_EN is undefined, q_gray SHALL NOT exist. All other behaviour is identical in both builds.

Verification
REQ-031 WIDTH=3, start=1, step=2, limit=7, dir=0, oneshot=0, load then en=1 for 5 clocks -> Q = 1,3,5,7,1; wrap high only with the final 1.
REQ-032 WIDTH=8, start=10, limit=40, step=15, dir=1, Q loaded to 40, en=1 -> Q = 25,10,40; wrap high with 40. Repeat from Q=12 -> 40 directly (12-15 underflows).
REQ-033 WIDTH=8, start=0, limit=255, step=1, dir=0, Q=255, en=1 -> Q=0, wrap=1, no X or overflow artefacts.
REQ-034 oneshot=1, WIDTH=3, start=1, step=2, limit=7 -> sequence stops at 1 with done=1. Further en cycles hold Q=1 and wrap=0. load clears done and the sequence resumes.
REQ-035 Assert clear asynchronously between edges while Q=5 and en=1 -> Q=RESET_VAL, wrap=0 and done=0 before the next edge. Simultaneous load=1 and en=1 -> Q=start.
REQ-036 With SEQGEN_GRAY_OUT_EN defined, run REQ-031 -> q_gray = 1,2,7,4,1. Build without the macro -> elaborates with no q_gray port.
